// File: rtl/pwm_cap_pkg.sv
// Shared types and constants for the PWM duty capture block.
package pwm_cap_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

    localparam int LUT_ENTRIES = 60;
    localparam int LUT_LAST    = 59;
    localparam int IDX_W       = 8;

    function automatic logic [31:0] abs_diff32(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction
endpackage

// File: rtl/lut_time_60.sv
// 60-entry duty table: entry i is i/59 of full scale, rounded to nearest.
module lut_time_60
    import pwm_cap_pkg::*;
#(
    parameter int DATA_W = 15
) (
    input  logic [7:0]        i_addr,
    output logic [DATA_W-1:0] o_data
);
    localparam int FULL = (1 << DATA_W) - 1;

    logic [DATA_W-1:0] w_table [0:63];

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_entry
            localparam int VAL = (gi < LUT_ENTRIES) ? (gi * FULL + LUT_LAST / 2) / LUT_LAST : 0;
            assign w_table[gi] = DATA_W'(VAL);
        end
    endgenerate

    assign o_data = (i_addr[7:6] == 2'b00) ? w_table[i_addr[5:0]] : '0;
endmodule

// File: rtl/pwm_edge_filter.sv
// Two-flop synchronizer plus run-length filter; level changes after FILT_LEN agreeing samples.
module pwm_edge_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic            r_sync1, r_sync2, r_level, r_rise, r_fall;
    logic [FC_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_rst_n || !i_en) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pwm;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == FC_W'(FILT_LEN - 1)) begin
                    r_level <= r_sync2;
                    r_rise  <= r_sync2;
                    r_fall  <= !r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + FC_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/pwm_duty_capture.sv
// PWM receive side: measures period/high time per cycle and maps duty to the nearest time index.
module pwm_duty_capture
    import pwm_cap_pkg::*;
#(
    parameter int PERIOD_DIV  = 19,
    parameter int MOD_WIDTH   = 15,
    parameter int CNT_W       = PERIOD_DIV + 1,
    parameter int FILT_LEN    = 3,
    parameter int TIMEOUT_CYC = 2 ** (PERIOD_DIV + 1)
) (
    input  logic                 clk,
    input  logic                 Rst_n,
    input  logic                 En,
    input  logic                 pwm_i,
    output logic [MOD_WIDTH-1:0] duty_o,
    output logic [CNT_W-1:0]     period_o,
    output logic [7:0]           time_o,
    output logic                 valid_o,
    output logic                 stuck_o,
    output logic                 overrun_o
);
    localparam int                   SHIFT    = PERIOD_DIV - MOD_WIDTH;
    localparam int                   TO_W     = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
    localparam logic [MOD_WIDTH-1:0] DUTY_MAX = '1;

    logic                 w_level, w_rise, w_fall, w_edge;
    logic                 w_measure, w_overrun_hit, w_timeout;
    state_t               r_state, w_state_next;
    logic                 r_armed;
    logic [CNT_W-1:0]     r_per_cnt, r_hi_cnt, r_period, w_hi_shift, w_period_new;
    logic [MOD_WIDTH-1:0] r_duty, w_duty_new, w_lut_data;
    logic [IDX_W-1:0]     r_idx, r_best_idx;
    logic [31:0]          r_best_diff, w_diff;
    logic [TO_W-1:0]      r_to_cnt;
    logic [MOD_WIDTH-1:0] r_duty_out;
    logic [CNT_W-1:0]     r_period_out;
    logic [IDX_W-1:0]     r_time_out;
    logic                 r_valid, r_stuck, r_overrun;

    pwm_edge_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .clk     (clk),
        .i_rst_n (Rst_n),
        .i_en    (En),
        .i_pwm   (pwm_i),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    lut_time_60 #(.DATA_W(MOD_WIDTH)) u_lut (
        .i_addr (r_idx),
        .o_data (w_lut_data)
    );

    assign w_edge        = w_rise || w_fall;
    assign w_measure     = w_rise && r_armed && (r_state == S_IDLE);
    assign w_overrun_hit = w_rise && r_armed && (r_state != S_IDLE);
    // Timeout is only acted on between searches so it never collides with a DONE strobe.
    assign w_timeout     = (r_to_cnt == TO_LAST) && !w_edge && !r_stuck && (r_state == S_IDLE);
    assign w_diff        = abs_diff32(32'(w_lut_data), 32'(r_duty));
    assign w_period_new  = (r_per_cnt == CNT_MAX) ? CNT_MAX : r_per_cnt + CNT_W'(1);

    always_comb begin
        w_hi_shift = r_hi_cnt >> SHIFT;
        if (w_hi_shift > CNT_W'(DUTY_MAX)) w_duty_new = DUTY_MAX;
        else                               w_duty_new = w_hi_shift[MOD_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!Rst_n || !En) r_state <= S_IDLE;
        else               r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_measure) w_state_next = S_SEARCH;
            S_SEARCH: if (r_idx == IDX_W'(LUT_LAST)) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            r_armed      <= 1'b0;
            r_per_cnt    <= '0;
            r_hi_cnt     <= '0;
            r_period     <= '0;
            r_duty       <= '0;
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_best_diff  <= '0;
            r_to_cnt     <= '0;
            r_duty_out   <= '0;
            r_period_out <= '0;
            r_time_out   <= '0;
            r_valid      <= 1'b0;
            r_stuck      <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (!En) begin
            r_armed     <= 1'b0;
            r_per_cnt   <= '0;
            r_hi_cnt    <= '0;
            r_period    <= '0;
            r_duty      <= '0;
            r_idx       <= '0;
            r_best_idx  <= '0;
            r_best_diff <= '0;
            r_to_cnt    <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            // The rising-edge cycle is already high, so the new high count starts at 1.
            if (w_rise) begin
                r_per_cnt <= '0;
                r_hi_cnt  <= CNT_W'(1);
                r_armed   <= 1'b1;
            end else begin
                if (r_per_cnt != CNT_MAX)             r_per_cnt <= r_per_cnt + CNT_W'(1);
                if (w_level && (r_hi_cnt != CNT_MAX)) r_hi_cnt  <= r_hi_cnt + CNT_W'(1);
            end

            if (w_measure) begin
                r_period    <= w_period_new;
                r_duty      <= w_duty_new;
                r_idx       <= '0;
                r_best_idx  <= '0;
                r_best_diff <= '1;
            end
            if (w_overrun_hit) r_overrun <= 1'b1;

            // Strict less-than keeps the lower index on ties.
            if (r_state == S_SEARCH) begin
                if (w_diff < r_best_diff) begin
                    r_best_diff <= w_diff;
                    r_best_idx  <= r_idx;
                end
                r_idx <= r_idx + IDX_W'(1);
            end

            if (r_state == S_DONE) begin
                r_duty_out   <= r_duty;
                r_period_out <= r_period;
                r_time_out   <= r_best_idx;
                r_valid      <= 1'b1;
            end

            if (w_edge) begin
                r_to_cnt <= '0;
                r_stuck  <= 1'b0;
            end else if (r_to_cnt != TO_LAST) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (w_timeout) begin
                r_stuck      <= 1'b1;
                r_armed      <= 1'b0;
                r_period_out <= '0;
                r_duty_out   <= w_level ? DUTY_MAX : '0;
                r_time_out   <= w_level ? IDX_W'(LUT_LAST) : '0;
                r_valid      <= 1'b1;
            end
        end
    end

    assign duty_o    = r_duty_out;
    assign period_o  = r_period_out;
    assign time_o    = r_time_out;
    assign valid_o   = r_valid;
    assign stuck_o   = r_stuck;
    assign overrun_o = r_overrun;
endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture with small sim parameters (256-cycle period, 4-bit duty).
module tb_pwm_duty_capture;
    localparam int PERIOD_DIV  = 8;
    localparam int MOD_WIDTH   = 4;
    localparam int CNT_W       = PERIOD_DIV + 1;
    localparam int FILT_LEN    = 3;
    localparam int TIMEOUT_CYC = 512;
    // pwm_i change -> filtered edge (2 + FILT_LEN) -> valid_o (62)
    localparam int LAT         = 2 + FILT_LEN + 62;
    // pwm_i change -> stuck strobe: filter delay + 1 clear cycle + TIMEOUT_CYC
    localparam int TO_LAT      = 2 + FILT_LEN + 1 + TIMEOUT_CYC;

    logic                 clk = 1'b0;
    logic                 Rst_n = 1'b0;
    logic                 En = 1'b0;
    logic                 pwm_i = 1'b0;
    logic [MOD_WIDTH-1:0] duty_o;
    logic [CNT_W-1:0]     period_o;
    logic [7:0]           time_o;
    logic                 valid_o, stuck_o, overrun_o;

    int cyc = 0;
    int valid_cnt = 0;
    int last_valid_cyc = -1;
    int n_checks = 0;
    int n_pass = 0;
    int rise_q[$];
    int fall_cyc;
    int vcnt0;
    int t0;

    pwm_duty_capture #(
        .PERIOD_DIV  (PERIOD_DIV),
        .MOD_WIDTH   (MOD_WIDTH),
        .CNT_W       (CNT_W),
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .Rst_n     (Rst_n),
        .En        (En),
        .pwm_i     (pwm_i),
        .duty_o    (duty_o),
        .period_o  (period_o),
        .time_o    (time_o),
        .valid_o   (valid_o),
        .stuck_o   (stuck_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
            $display("ok   %-16s = %0d", tag, obs);
        end else begin
            $display("FAIL %-16s got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pwm_periods(input int period, input int high, input int n);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < period; c++) begin
                pwm_i = (c < high);
                if (c == 0)    rise_q.push_back(cyc);
                if (c == high) fall_cyc = cyc;
                tick();
            end
        end
    endtask

    initial begin
        // 1: reset held while the line toggles
        Rst_n = 1'b0;
        En    = 1'b1;
        @(posedge clk);
        #1;
        pwm_i = 1'b1;
        tick();
        pwm_i = 1'b0;
        chk("rst_known", $isunknown({duty_o, period_o, time_o, valid_o, stuck_o, overrun_o}), 0);
        chk("rst_outputs", {duty_o, period_o, time_o, valid_o, stuck_o, overrun_o}, 0);
        chk("rst_no_valid", valid_cnt, 0);
        Rst_n = 1'b1;
        tick(5);

        // 2: 256-cycle period, setpoint 8 (table entry 30) -> 128 high cycles
        rise_q.delete();
        pwm_periods(256, 128, 2);
        pwm_i = 1'b0;
        tick(80);
        chk("meas_valid_cnt", valid_cnt, 1);
        chk("meas_latency", last_valid_cyc - rise_q[1], LAT);
        chk("meas_period", period_o, 256);
        chk("meas_duty", duty_o, 8);
        chk("meas_time", time_o, 30);
        chk("meas_stuck", stuck_o, 0);
        chk("meas_overrun", overrun_o, 0);

        // 4: short glitches on a low line, then the low-line timeout must keep its original timing
        vcnt0 = valid_cnt;
        pwm_i = 1'b1;
        tick();
        pwm_i = 1'b0;
        tick(10);
        pwm_i = 1'b1;
        tick(2);
        pwm_i = 1'b0;
        tick(10);
        chk("glitch_no_valid", valid_cnt - vcnt0, 0);
        chk("glitch_period", period_o, 256);
        while (cyc < fall_cyc + TO_LAT + 3) tick();
        chk("to_lo_stuck", stuck_o, 1);
        chk("to_lo_timing", last_valid_cyc - fall_cyc, TO_LAT);
        chk("to_lo_one_valid", valid_cnt - vcnt0, 1);
        chk("to_lo_duty", duty_o, 0);
        chk("to_lo_time", time_o, 0);
        chk("to_lo_period", period_o, 0);

        // 3: line held high for 600 cycles
        vcnt0 = valid_cnt;
        pwm_i = 1'b1;
        t0 = cyc;
        tick(10);
        chk("hi_clears_stuck", stuck_o, 0);
        while (cyc < t0 + 600) tick();
        chk("to_hi_stuck", stuck_o, 1);
        chk("to_hi_duty", duty_o, 15);
        chk("to_hi_time", time_o, 59);
        chk("to_hi_period", period_o, 0);
        chk("to_hi_one_valid", valid_cnt - vcnt0, 1);
        chk("to_hi_timing", last_valid_cyc - t0, TO_LAT);
        pwm_i = 1'b0;
        tick(10);
        chk("fall_clears", stuck_o, 0);

        // 5: 40-cycle period, 20 high: shorter than the search, alternate edges overrun
        vcnt0 = valid_cnt;
        rise_q.delete();
        pwm_periods(40, 20, 2);
        chk("ovr_before", overrun_o, 0);
        pwm_periods(40, 20, 4);
        pwm_i = 1'b0;
        tick(100);
        chk("ovr_set", overrun_o, 1);
        chk("ovr_valid_cnt", valid_cnt - vcnt0, 3);
        chk("ovr_period", period_o, 40);
        chk("ovr_duty", duty_o, 1);
        chk("ovr_time", time_o, 2);

        // 6a: En dropped mid-search -> no strobe, outputs hold
        vcnt0 = valid_cnt;
        pwm_i = 1'b1;
        tick(25);
        En = 1'b0;
        tick(5);
        chk("en_lo_valid", valid_o, 0);
        En = 1'b1;
        tick(100);
        chk("en_no_strobe", valid_cnt - vcnt0, 0);
        chk("en_hold_period", period_o, 40);
        chk("en_hold_duty", duty_o, 1);
        chk("en_hold_time", time_o, 2);
        chk("ovr_sticky", overrun_o, 1);

        // 6b: reset at search step 20
        pwm_i = 1'b0;
        tick(20);
        pwm_i = 1'b1;
        tick(2 + FILT_LEN + 1 + 20);
        Rst_n = 1'b0;
        tick(2);
        Rst_n = 1'b1;
        vcnt0 = valid_cnt;
        chk("rst_mid_time", time_o, 0);
        chk("rst_mid_period", period_o, 0);
        chk("rst_mid_overrun", overrun_o, 0);
        tick(100);
        chk("rst_mid_no_valid", valid_cnt - vcnt0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
